// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: scoreboard-driven forwarding, load-use stall and branch flush control
// for a five-stage MIPS pipeline. Define HAZ_PERF_CNT_EN to add saturating stall/flush counters.
module pipe_hazard_unit #(
  parameter int AW       = 5,
  parameter int BR_STAGE = 2,
  parameter int CNT_W    = 32
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          ValidD,
  input  logic [AW-1:0] RsD,
  input  logic [AW-1:0] RtD,
  input  logic          UseRsD,
  input  logic          UseRtD,
  input  logic [AW-1:0] WriteRegD,
  input  logic          RegWriteD,
  input  logic          MemtoRegD,
  input  logic          BranchTaken,
  output logic          StallF,
  output logic          StallD,
  output logic          FlushD,
  output logic          FlushE,
  output logic [1:0]    ForwardAE,
  output logic [1:0]    ForwardBE,
  output logic          ForwardAD,
  output logic          ForwardBD
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
`endif
);

  // Scoreboard entries: _p0 = Execute, _p1 = Memory, _p2 = Writeback
  logic          vld_p0, vld_p1, vld_p2;
  logic          rw_p0, rw_p1, rw_p2;
  logic          mr_p0, mr_p1;
  logic [AW-1:0] dest_p0, dest_p1, dest_p2;
  logic [AW-1:0] rs_p0, rt_p0;

  logic src_p0, src_p1, src_p2;
  logic hit_p0, hit_p1;
  logic load_use, stall, squash;

  always_comb begin
    src_p0 = vld_p0 & rw_p0 & (|dest_p0);
    src_p1 = vld_p1 & rw_p1 & (|dest_p1);
    src_p2 = vld_p2 & rw_p2 & (|dest_p2);

    hit_p0 = (UseRsD && (RsD == dest_p0)) || (UseRtD && (RtD == dest_p0));
    hit_p1 = (UseRsD && (RsD == dest_p1)) || (UseRtD && (RtD == dest_p1));

    load_use = ValidD & ((src_p0 & mr_p0 & hit_p0) | (src_p1 & mr_p1 & hit_p1));
    // A taken branch discards the dependent instruction, so it never stalls
    stall  = load_use & ~BranchTaken;
    squash = BranchTaken && (BR_STAGE == 2);

    StallF = stall;
    StallD = stall;
    FlushD = Rst & BranchTaken;
    FlushE = Rst & (BranchTaken | stall);

    ForwardAE = (src_p1 && !mr_p1 && (dest_p1 == rs_p0)) ? 2'b10 :
                (src_p2 && (dest_p2 == rs_p0))           ? 2'b01 : 2'b00;
    ForwardBE = (src_p1 && !mr_p1 && (dest_p1 == rt_p0)) ? 2'b10 :
                (src_p2 && (dest_p2 == rt_p0))           ? 2'b01 : 2'b00;

    ForwardAD = src_p2 && (dest_p2 == RsD) && UseRsD;
    ForwardBD = src_p2 && (dest_p2 == RtD) && UseRtD;
  end

  // D -> E -> M -> W advance; only valid bits carry reset
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p0 <= ValidD & ~FlushE;
      vld_p1 <= vld_p0 & ~squash;
      vld_p2 <= vld_p1;
    end
  end

  always_ff @(posedge Clk) begin
    rw_p0   <= RegWriteD;
    mr_p0   <= MemtoRegD;
    dest_p0 <= WriteRegD;
    rs_p0   <= RsD;
    rt_p0   <= RtD;
    rw_p1   <= rw_p0;
    mr_p1   <= mr_p0;
    dest_p1 <= dest_p0;
    rw_p2   <= rw_p1;
    dest_p2 <= dest_p1;
  end

`ifdef HAZ_PERF_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if (stall)       StallCnt <= sat_inc(StallCnt);
      if (BranchTaken) FlushCnt <= sat_inc(FlushCnt);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: directed scenarios plus random traffic against an
// instruction-level pipeline model. Counter checks are active with HAZ_PERF_CNT_EN.
module tb_pipe_hazard_unit;
  localparam int AW    = 5;
  localparam int BR    = 2;
  localparam int CNT_W = 4;

  logic          Clk, Rst, ValidD, UseRsD, UseRtD, RegWriteD, MemtoRegD, BranchTaken;
  logic [AW-1:0] RsD, RtD, WriteRegD;
  logic          StallF, StallD, FlushD, FlushE, ForwardAD, ForwardBD;
  logic [1:0]    ForwardAE, ForwardBE;
`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] StallCnt, FlushCnt;
`endif

  int total = 0;
  int bad   = 0;

  pipe_hazard_unit #(.AW(AW), .BR_STAGE(BR), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Rst(Rst), .ValidD(ValidD), .RsD(RsD), .RtD(RtD),
    .UseRsD(UseRsD), .UseRtD(UseRtD), .WriteRegD(WriteRegD),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .BranchTaken(BranchTaken),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD)
`ifdef HAZ_PERF_CNT_EN
    , .StallCnt(StallCnt), .FlushCnt(FlushCnt)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Instruction-level model: pipe[0]=E, pipe[1]=M, pipe[2]=W
  typedef struct packed {
    logic          v;
    logic          wr;
    logic          ld;
    logic [AW-1:0] d;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
  } instr_t;

  instr_t pipe [3];
  instr_t incoming;
  logic   exp_stall, exp_fd, exp_fe, exp_ad, exp_bd;
  logic [1:0] exp_ae, exp_be;
`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] exp_sc, exp_fc;
`endif

  function automatic logic writes(input instr_t i);
    return i.v && i.wr && (i.d != 0);
  endfunction

  function automatic logic [1:0] fwd_of(input instr_t m, input instr_t w, input logic [AW-1:0] r);
    if (writes(m) && !m.ld && m.d == r) return 2'd2;
    if (writes(w) && w.d == r) return 2'd1;
    return 2'd0;
  endfunction

  always_comb begin
    exp_stall = 1'b0;
    if (ValidD)
      for (int i = 0; i < 2; i++)
        if (writes(pipe[i]) && pipe[i].ld &&
            ((UseRsD && RsD == pipe[i].d) || (UseRtD && RtD == pipe[i].d)))
          exp_stall = 1'b1;
    if (BranchTaken) exp_stall = 1'b0;
    exp_fd = Rst && BranchTaken;
    exp_fe = Rst && (BranchTaken || exp_stall);
    exp_ae = fwd_of(pipe[1], pipe[2], pipe[0].rs);
    exp_be = fwd_of(pipe[1], pipe[2], pipe[0].rt);
    exp_ad = writes(pipe[2]) && pipe[2].d == RsD && UseRsD;
    exp_bd = writes(pipe[2]) && pipe[2].d == RtD && UseRtD;
    incoming = '{v: ValidD && !exp_fe, wr: RegWriteD, ld: MemtoRegD, d: WriteRegD, rs: RsD, rt: RtD};
  end

  always @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < 3; i++) pipe[i] <= '0;
`ifdef HAZ_PERF_CNT_EN
      exp_sc <= '0;
      exp_fc <= '0;
`endif
    end else begin
      pipe[0] <= incoming;
      pipe[1] <= (BranchTaken && BR == 2) ? '0 : pipe[0];
      pipe[2] <= pipe[1];
`ifdef HAZ_PERF_CNT_EN
      if (exp_stall && exp_sc != '1) exp_sc <= exp_sc + 1'b1;
      if (BranchTaken && exp_fc != '1) exp_fc <= exp_fc + 1'b1;
`endif
    end
  end

  task automatic drive(input logic v, input int rs, input int rt, input logic urs, input logic urt,
                       input int wd, input logic rw, input logic mr, input logic br);
    ValidD = v; RsD = rs[AW-1:0]; RtD = rt[AW-1:0]; UseRsD = urs; UseRtD = urt;
    WriteRegD = wd[AW-1:0]; RegWriteD = rw; MemtoRegD = mr; BranchTaken = br;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic clean();
    repeat (4) begin @(negedge Clk); nop(); end
  endtask

  task automatic test_reset();
    Rst = 1'b0;
    drive(1, 1, 2, 1, 1, 3, 1, 1, 1);
    #12;
    total++;
    if ({StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, ForwardAD, ForwardBD} !== 10'b0) begin
      bad++;
      $display("FAIL reset_outputs got=%b exp=0",
               {StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, ForwardAD, ForwardBD});
    end
`ifdef HAZ_PERF_CNT_EN
    total++;
    if ({StallCnt, FlushCnt} !== '0) begin
      bad++; $display("FAIL reset_counters got=%h/%h exp=0/0", StallCnt, FlushCnt);
    end
`endif
    @(negedge Clk); nop(); Rst = 1'b1;
    clean();
  endtask

  task automatic test_alu_forward();
    @(negedge Clk); drive(1, 2, 3, 1, 1, 1, 1, 0, 0);   // add $1,$2,$3
    @(negedge Clk); drive(1, 1, 5, 1, 1, 4, 1, 0, 0);   // sub $4,$1,$5
    @(negedge Clk); drive(1, 1, 7, 1, 1, 6, 1, 0, 0);   // and $6,$1,$7
    #1;
    total++;
    if (ForwardAE !== 2'b10) begin bad++; $display("FAIL fwd_ae_mem got=%b exp=10", ForwardAE); end
    total++;
    if (ForwardBE !== 2'b00) begin bad++; $display("FAIL fwd_be_none got=%b exp=00", ForwardBE); end
    @(negedge Clk); nop();
    #1;
    total++;
    if (ForwardAE !== 2'b01) begin bad++; $display("FAIL fwd_ae_wb got=%b exp=01", ForwardAE); end
    clean();
  endtask

  task automatic test_load_use();
    int stalls;
    logic done;
    stalls = 0;
    done = 1'b0;
    @(negedge Clk); drive(1, 0, 0, 1, 0, 1, 1, 1, 0);   // lw $1,0($0)
    @(negedge Clk); drive(1, 1, 1, 1, 1, 2, 1, 0, 0);   // add $2,$1,$1
    #1;
    for (int k = 0; k < 6 && !done; k++) begin
      if (StallD === 1'b1) begin
        stalls++;
        total++;
        if (FlushE !== 1'b1 || StallF !== 1'b1) begin
          bad++; $display("FAIL lu_flush_e got=%b%b exp=11", FlushE, StallF);
        end
        @(negedge Clk); #1;
      end else done = 1'b1;
    end
    total++;
    if (stalls != 2) begin bad++; $display("FAIL lu_stall_cycles got=%0d exp=2", stalls); end
    total++;
    if ({ForwardAD, ForwardBD} !== 2'b11) begin
      bad++; $display("FAIL lu_decode_bypass got=%b exp=11", {ForwardAD, ForwardBD});
    end
`ifdef HAZ_PERF_CNT_EN
    @(negedge Clk); nop(); #1;
    total++;
    if (StallCnt !== 4'd2) begin bad++; $display("FAIL lu_stall_cnt got=%0d exp=2", StallCnt); end
`endif
    clean();
  endtask

  task automatic test_decode_bypass();
    @(negedge Clk); drive(1, 4, 5, 1, 1, 3, 1, 0, 0);   // writes $3
    @(negedge Clk); nop();
    @(negedge Clk); nop();
    @(negedge Clk); drive(1, 3, 6, 1, 1, 7, 1, 0, 0);   // reads $3
    #1;
    total++;
    if ({ForwardAD, ForwardBD} !== 2'b10) begin
      bad++; $display("FAIL dbyp_r3 got=%b exp=10", {ForwardAD, ForwardBD});
    end
    clean();
    @(negedge Clk); drive(1, 0, 0, 1, 0, 0, 1, 1, 0);   // load into $0
    @(negedge Clk); drive(1, 0, 0, 1, 1, 8, 1, 0, 0);   // reads $0
    #1;
    total++;
    if ({StallF, StallD, ForwardAD, ForwardBD} !== 4'b0) begin
      bad++; $display("FAIL r0_no_stall got=%b exp=0000", {StallF, StallD, ForwardAD, ForwardBD});
    end
    @(negedge Clk); nop(); @(negedge Clk); nop(); #1;
    total++;
    if ({ForwardAE, ForwardBE, ForwardAD, ForwardBD} !== 6'b0) begin
      bad++; $display("FAIL r0_no_fwd got=%b exp=0", {ForwardAE, ForwardBE, ForwardAD, ForwardBD});
    end
    clean();
  endtask

  task automatic test_branch_over_stall();
    @(negedge Clk); drive(1, 0, 0, 1, 0, 1, 1, 1, 0);   // lw $1
    @(negedge Clk); drive(1, 1, 1, 1, 1, 2, 1, 0, 1);   // dependent add, branch taken
    #1;
    total++;
    if ({FlushD, FlushE, StallF, StallD} !== 4'b1100) begin
      bad++; $display("FAIL br_priority got=%b exp=1100", {FlushD, FlushE, StallF, StallD});
    end
    @(negedge Clk); drive(1, 1, 0, 1, 0, 9, 1, 0, 0);   // would stall if lw survived into M
    #1;
    total++;
    if (StallD !== 1'b0) begin bad++; $display("FAIL br_squash_m got=%b exp=0", StallD); end
`ifdef HAZ_PERF_CNT_EN
    total++;
    if (FlushCnt !== 4'd1) begin bad++; $display("FAIL br_flush_cnt got=%0d exp=1", FlushCnt); end
`endif
    clean();
  endtask

  task automatic test_reset_mid_stall();
    @(negedge Clk); drive(1, 0, 0, 1, 0, 1, 1, 1, 0);   // lw $1
    @(negedge Clk); drive(1, 1, 1, 1, 1, 2, 1, 0, 0);   // add $2,$1,$1
    #1;
    total++;
    if (StallD !== 1'b1) begin bad++; $display("FAIL mr_pre_stall got=%b exp=1", StallD); end
    #2 Rst = 1'b0;
    #1;
    total++;
    if ({StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, ForwardAD, ForwardBD} !== 10'b0) begin
      bad++;
      $display("FAIL mr_async_clear got=%b exp=0",
               {StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, ForwardAD, ForwardBD});
    end
    @(negedge Clk); Rst = 1'b1;
    #1;
    total++;
    if (StallD !== 1'b0) begin bad++; $display("FAIL mr_no_stall got=%b exp=0", StallD); end
    @(negedge Clk); drive(1, 2, 0, 1, 0, 10, 1, 0, 0);  // reads $2
    @(negedge Clk); nop(); #1;
    total++;
    if (ForwardAE !== 2'b10) begin bad++; $display("FAIL mr_advance got=%b exp=10", ForwardAE); end
    clean();
  endtask

  task automatic test_random();
    logic [9:0] got, exp;
    for (int c = 0; c < 400; c++) begin
      @(negedge Clk);
      drive(($urandom_range(0, 7) != 0), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
            $urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 7) == 0));
      #1;
      got = {StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, ForwardAD, ForwardBD};
      exp = {exp_stall, exp_stall, exp_fd, exp_fe, exp_ae, exp_be, exp_ad, exp_bd};
      total++;
      if (got !== exp) begin bad++; $display("FAIL rnd_cycle%0d got=%b exp=%b", c, got, exp); end
`ifdef HAZ_PERF_CNT_EN
      total++;
      if ({StallCnt, FlushCnt} !== {exp_sc, exp_fc}) begin
        bad++; $display("FAIL rnd_cnt%0d got=%0d/%0d exp=%0d/%0d", c, StallCnt, FlushCnt, exp_sc, exp_fc);
      end
`endif
    end
    clean();
  endtask

  task automatic test_flush_saturate();
`ifdef HAZ_PERF_CNT_EN
    @(negedge Clk); Rst = 1'b0;
    @(negedge Clk); Rst = 1'b1;
    repeat ((1 << CNT_W) + 2) begin
      @(negedge Clk); drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    end
    @(negedge Clk); nop(); #1;
    total++;
    if (FlushCnt !== 4'd15) begin bad++; $display("FAIL flush_sat got=%0d exp=15", FlushCnt); end
    clean();
`endif
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu_forward();
    test_load_use();
    test_decode_bypass();
    test_branch_over_stall();
    test_reset_mid_stall();
    test_random();
    test_flush_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
